// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg: shared constants and state encoding for the iterative multiplier.
package mul_iter_pkg;

    localparam logic       MulStart    = 1'b1;
    localparam logic       MulStop     = 1'b0;
    localparam logic       MulReady    = 1'b1;
    localparam logic       MulNotReady = 1'b0;

    localparam logic [1:0] MulSignUU   = 2'b00;
    localparam logic [1:0] MulSignSS   = 2'b01;
    localparam logic [1:0] MulSignSU   = 2'b10;

    typedef enum logic [2:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_FIX,
        S_END
    } state_e;

endpackage

// File: rtl/mul_iter_pp.sv
// mul_iter_pp: STEP-bit partial product of a pre-shifted multiplicand.
module mul_iter_pp #(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [STEP-1:0]    i_bits,
    output logic [2*WIDTH-1:0] o_pp
);

    always_comb begin
        o_pp = '0;
        for (int j = 0; j < STEP; j++)
            if (i_bits[j]) o_pp = o_pp + (i_mcand << j);
    end

endmodule

// File: rtl/mul_iter.sv
// mul_iter: sign-magnitude shift-add multiplier with optional accumulate,
// retiring STEP multiplier bits per cycle.
module mul_iter import mul_iter_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [1:0]         sign_mode_i,
    input  logic               acc_en_i,
    input  logic               acc_sub_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);
    localparam int W2 = 2 * WIDTH;

    state_e           r_state, w_next;
    logic [W2-1:0]    r_mcand, r_sum, r_acc, r_res, w_pp, w_prod, w_fix;
    logic [WIDTH-1:0] r_mplier, w_mag1, w_mag2;
    logic [CW-1:0]    r_cnt;
    logic             r_neg, r_acc_en, r_acc_sub, r_ready;
    logic             w_neg1, w_neg2, w_accept;

    assign w_neg1   = (sign_mode_i == MulSignSS || sign_mode_i == MulSignSU) && opdata1_i[WIDTH-1];
    assign w_neg2   = (sign_mode_i == MulSignSS) && opdata2_i[WIDTH-1];
    assign w_mag1   = w_neg1 ? -opdata1_i : opdata1_i;
    assign w_mag2   = w_neg2 ? -opdata2_i : opdata2_i;
    assign w_accept = r_state == S_FREE && start_i == MulStart && !annul_i;
    assign w_prod   = r_neg ? -r_sum : r_sum;
    assign w_fix    = !r_acc_en ? w_prod : r_acc_sub ? r_acc - w_prod : r_acc + w_prod;

    assign ready_o  = r_ready;
    assign busy_o   = r_state != S_FREE;
    assign result_o = r_ready ? r_res : '0;

    mul_iter_pp #(.WIDTH(WIDTH), .STEP(STEP)) u_pp (
        .i_mcand (r_mcand),
        .i_bits  (r_mplier[STEP-1:0]),
        .o_pp    (w_pp)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= S_FREE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FREE:   if (w_accept) w_next = (opdata1_i == '0 || opdata2_i == '0) ? S_BYZERO : S_ON;
            S_BYZERO: w_next = annul_i ? S_FREE : S_END;
            S_ON:     w_next = annul_i ? S_FREE : (r_cnt == CW'(N - 1)) ? S_FIX : S_ON;
            S_FIX:    w_next = annul_i ? S_FREE : S_END;
            S_END:    w_next = (r_ready && start_i == MulStop) ? S_FREE : S_END;
            default:  w_next = S_FREE;
        endcase
    end

    // ready lags entry to END by one edge so latency lands on the +2 boundary
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_sum     <= '0;
            r_acc     <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_acc_en  <= 1'b0;
            r_acc_sub <= 1'b0;
            r_ready   <= MulNotReady;
        end else begin
            r_ready <= (r_state == S_END && w_next == S_END) ? MulReady : MulNotReady;
            case (r_state)
                S_FREE: if (w_accept) begin
                    r_mcand   <= W2'(w_mag1);
                    r_mplier  <= w_mag2;
                    r_neg     <= w_neg1 ^ w_neg2;
                    r_acc_en  <= acc_en_i;
                    r_acc_sub <= acc_sub_i;
                    r_acc     <= acc_i;
                    r_sum     <= '0;
                    r_res     <= '0;
                    r_cnt     <= '0;
                end
                S_ON: begin
                    r_sum    <= r_sum + w_pp;
                    r_mcand  <= r_mcand << STEP;
                    r_mplier <= r_mplier >> STEP;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_BYZERO: r_res <= r_acc_en ? r_acc : '0;
                S_FIX:    r_res <= w_fix;
                default: ;
            endcase
        end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed checks of mul_iter latency, arithmetic, annul and reset.
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start2 = 1'b0, start1 = 1'b0, start4 = 1'b0;
    logic        annul = 1'b0;
    logic [1:0]  sm = 2'b00;
    logic        acc_en = 1'b0, acc_sub = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [63:0] acc = '0;
    logic [63:0] res2, res1, res4;
    logic        ready2, ready1, ready4, busy2, busy1, busy4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_iter #(.WIDTH(32), .STEP(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .annul_i(annul), .sign_mode_i(sm),
        .acc_en_i(acc_en), .acc_sub_i(acc_sub), .opdata1_i(op1), .opdata2_i(op2),
        .acc_i(acc), .result_o(res2), .ready_o(ready2), .busy_o(busy2));

    mul_iter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .annul_i(annul), .sign_mode_i(sm),
        .acc_en_i(acc_en), .acc_sub_i(acc_sub), .opdata1_i(op1), .opdata2_i(op2),
        .acc_i(acc), .result_o(res1), .ready_o(ready1), .busy_o(busy1));

    mul_iter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .annul_i(annul), .sign_mode_i(sm),
        .acc_en_i(acc_en), .acc_sub_i(acc_sub), .opdata1_i(op1), .opdata2_i(op2),
        .acc_i(acc), .result_o(res4), .ready_o(ready4), .busy_o(busy4));

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic ae, input logic as, input logic [63:0] ac);
        sm = s; op1 = a; op2 = b; acc_en = ae; acc_sub = as; acc = ac;
    endtask

    task automatic scramble();
        op1 = $urandom; op2 = $urandom; acc = {$urandom, $urandom};
        sm = 2'($urandom); acc_en = 1'($urandom); acc_sub = 1'($urandom);
    endtask

    task automatic do_op(input string name, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic ae, input logic as,
                         input logic [63:0] ac, input int exp_lat, input logic [63:0] exp_res,
                         input int hold);
        int lat;
        logic [63:0] first;
        @(negedge clk);
        set_op(s, a, b, ae, as, ac);
        start2 = 1'b1;
        @(posedge clk); #1;
        scramble();
        lat = 0;
        while (!ready2 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(exp_lat));
        check({name, " result"}, 128'(res2), 128'(exp_res));
        first = res2;
        for (int i = 0; i < hold; i++) begin
            if (hold > 2) annul = 1'b1;
            @(posedge clk); #1;
            check({name, " hold"}, {63'd0, ready2, res2}, {63'd0, 1'b1, first});
        end
        start2 = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        check({name, " release"}, {62'd0, ready2, busy2, res2}, 128'd0);
    endtask

    initial begin
        int k, lat1, lat4;
        #2;
        check("reset outputs", {62'd0, ready2, busy2, res2}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle outputs", {62'd0, ready2, busy2, res2}, 128'd0);

        do_op("ss -1x3", 2'b01, 32'hFFFF_FFFF, 32'h3, 1'b0, 1'b0, 64'd0, 18, 64'hFFFF_FFFF_FFFF_FFFD, 2);
        do_op("uu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0, 18, 64'hFFFF_FFFE_0000_0001, 2);
        do_op("zero acc", 2'b00, 32'h0, 32'h1234, 1'b1, 1'b0, 64'h0000_0001_0000_0005, 2, 64'h0000_0001_0000_0005, 2);
        do_op("zero op2", 2'b01, 32'h5555, 32'h0, 1'b0, 1'b0, 64'h77, 2, 64'd0, 2);
        do_op("ss min sub", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'd0, 18, 64'hC000_0000_0000_0000, 2);
        do_op("su -2x2", 2'b10, 32'hFFFF_FFFE, 32'h2, 1'b0, 1'b0, 64'd0, 18, 64'hFFFF_FFFF_FFFF_FFFC, 2);
        do_op("su -1xmax", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0, 18, 64'hFFFF_FFFF_0000_0001, 2);
        do_op("mode11 uu", 2'b11, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 64'd0, 18, 64'h0000_0001_FFFF_FFFE, 2);
        do_op("uu acc add", 2'b00, 32'h3, 32'h5, 1'b1, 1'b0, 64'h100, 18, 64'h10F, 2);
        do_op("ss acc add", 2'b01, 32'hFFFF_FFFD, 32'h5, 1'b1, 1'b0, 64'd20, 18, 64'h5, 2);

        @(negedge clk);
        set_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0);
        start1 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        scramble();
        k = 0; lat1 = 0; lat4 = 0;
        while ((lat1 == 0 || lat4 == 0) && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (ready1 && lat1 == 0) lat1 = k;
            if (ready4 && lat4 == 0) lat4 = k;
        end
        check("step1 latency", 128'(lat1), 128'd34);
        check("step4 latency", 128'(lat4), 128'd10);
        check("step1 result", 128'(res1), 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001);
        check("step4 result", 128'(res4), 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001);
        start1 = 1'b0; start4 = 1'b0;
        @(posedge clk); #1;
        check("step1/4 release", {60'd0, ready1, busy1, ready4, busy4, res1 | res4}, 128'd0);

        @(negedge clk);
        set_op(2'b00, 32'd7, 32'd9, 1'b0, 1'b0, 64'd0);
        start2 = 1'b1;
        @(posedge clk); #1;
        k = 0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            if (ready2) k++;
        end
        check("annul busy before", {126'd0, busy2}, 128'd1);
        annul = 1'b1;
        @(posedge clk); #1;
        check("annul outputs", {62'd0, ready2, busy2, res2}, 128'd0);
        check("annul no ready", 128'(k), 128'd0);
        annul = 1'b0; start2 = 1'b0;
        do_op("after annul", 2'b00, 32'd7, 32'd9, 1'b0, 1'b0, 64'd0, 18, 64'h3F, 2);

        @(negedge clk);
        set_op(2'b01, 32'h1234, 32'h5678, 1'b0, 1'b0, 64'd0);
        start2 = 1'b1;
        for (int e = 0; e < 4; e++) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async reset", {62'd0, ready2, busy2, res2}, 128'd0);
        start2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post reset idle", {62'd0, ready2, busy2, res2}, 128'd0);

        do_op("hold 10", 2'b00, 32'h1234_5678, 32'h10, 1'b0, 1'b0, 64'd0, 18, 64'h0000_0001_2345_6780, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter STEP, default 2, SHALL set the multiplier bits retired per iteration cycle; legal values are 1, 2 and 4, and WIDTH SHALL be divisible by STEP.
REQ-003 Ports SHALL be, as name, direction, width and meaning:
- clk  in  1  clock; rising edge active.
- rst  in  1  one clock; reset is asynchronous and active-low.
- start_i  in  1  1 requests a multiply; must be held until ready_o is seen, then dropped.
- annul_i  in  1  1 cancels the operation in flight.
- sign_mode_i  in  2  00 unsigned×unsigned, 01 signed×signed, 10 signed op1 × unsigned op2, 11 reserved (treated as 00).
- acc_en_i  in  1  1 adds acc_i to the product.
- acc_sub_i  in  1  with acc_en_i, 1 subtracts the product from acc_i.
- opdata1_i  in  WIDTH  multiplicand.
- opdata2_i  in  WIDTH  multiplier.
- acc_i  in  2*WIDTH  accumulator operand.
- result_o  out  2*WIDTH  result; valid while ready_o=1.
- ready_o  out  1  result valid.
- busy_o  out  1  1 in any state other than FREE.

Function
REQ-004 The FSM SHALL have the states FREE, BYZERO, ON, FIX and END.
REQ-005 In FREE, start_i=1 with annul_i=0 SHALL be accepted at that edge, and the block SHALL latch opdata1_i, opdata2_i, sign_mode_i, acc_en_i, acc_sub_i and acc_i; inputs after acceptance SHALL be ignored.
REQ-006 On acceptance, if either operand is 0 the FSM SHALL go to BYZERO, otherwise to ON with the iteration counter at 0.
REQ-007 Signed operands SHALL be converted to magnitudes at acceptance, and the result sign SHALL be recorded as the XOR of the operand signs (signed operands only).
REQ-008 Each ON cycle SHALL add (multiplier LSB group × shifted multiplicand) to a 2*WIDTH partial sum, shift the multiplicand left by STEP, shift the multiplier right by STEP, and increment the counter.
REQ-009 After WIDTH/STEP ON cycles the FSM SHALL go to FIX; an early exit when the remaining multiplier bits are 0 is permitted only if latency is still padded to REQ-012.
REQ-010 FIX SHALL negate the partial sum if the recorded result sign is 1, then apply the accumulate: result = acc ± product, modulo 2^(2*WIDTH).
REQ-011 BYZERO SHALL produce product 0 (the result becomes acc_i when acc_en_i=1) and go to END.
REQ-012 With the acceptance edge as edge 0, ready_o SHALL rise after edge 2 on the zero path and after edge WIDTH/STEP+2 otherwise.
REQ-013 In END, ready_o=1 and result_o SHALL hold stable while start_i=1.
REQ-014 In END, start_i=0 SHALL, at the next edge, return the FSM to FREE with ready_o=0 and result_o=0.
REQ-015 annul_i=1 in ON, FIX or BYZERO SHALL return the FSM to FREE at the next edge with ready_o never asserted.
REQ-016 annul_i in END SHALL be ignored.
REQ-017 In FREE without acceptance, ready_o=0 and result_o=0.
REQ-018 Mixed-signed mode SHALL treat op2 as unsigned, and the most negative signed operand (e.g. 0x80000000) SHALL produce the exact product.

Reset
REQ-019 rst=0 SHALL asynchronously force state=FREE, ready_o=0, busy_o=0, result_o=0 and clear all internal registers, including when asserted mid-operation.
REQ-020 After rst is released, the first acceptance SHALL occur no earlier than the first rising edge with rst=1.

Structure
REQ-021 State encodings, sign_mode codes, and the start/stop and ready/not-ready constants SHALL live in the shared defines package next to the existing Mul* constants.
REQ-022 One sub-module, mul_iter_pp (combinational STEP-bit partial-product generator, WIDTH×STEP), SHALL be instantiated once.

Verification (WIDTH=32, STEP=2 unless stated)
REQ-023 Signed 0xFFFFFFFF × 0x00000003, no accumulate -> ready_o rises after edge 18, result 0xFFFFFFFFFFFFFFFD.
REQ-024 Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> result 0xFFFFFFFE00000001; repeat with STEP=1 (ready after edge 34) and STEP=4 (ready after edge 10).
REQ-025 Operand 0 with acc_en_i=1 and acc_i=0x0000000100000005 -> ready_o after edge 2, result 0x0000000100000005.
REQ-026 Signed 0x80000000 × 0x80000000 with acc_en_i=1, acc_sub_i=1, acc_i=0 -> result 0xC000000000000000; mixed mode 0xFFFFFFFE × 0x00000002 -> 0xFFFFFFFFFFFFFFFC.
REQ-027 annul_i pulsed at edge 5 of an operation -> busy_o=0 after edge 6, ready_o stays 0; a new start then completes correctly.
REQ-028 rst driven low mid-ON, between clock edges -> all outputs 0 immediately; start_i held high through END for 10 cycles -> result_o stable, then drop start_i -> FREE and result_o=0 after one edge.
